// File: rtl/hazard_ctrl_mc_if.sv
// Hazard controller bus: register addresses and control flags coming from the
// datapath, plus forwarding selects and stall/flush enables going back to it.
// master = datapath side, slave = hazard controller side.
interface hazard_ctrl_mc_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs1_d, rs2_d;
  logic [REG_AW-1:0] rs1_e, rs2_e;
  logic [REG_AW-1:0] rd_e, rd_m, rd_w;
  logic              reg_write_m, reg_write_w;
  logic [1:0]        result_src_e;
  logic              pc_src_e;
  logic              mc_start_e;
  logic              mc_done;
  logic [1:0]        forward_a_e, forward_b_e;
  logic              stall_f, stall_d, stall_e;
  logic              flush_d, flush_e, flush_m;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output reg_write_m, reg_write_w, result_src_e, pc_src_e, mc_start_e, mc_done,
    input  forward_a_e, forward_b_e,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  reg_write_m, reg_write_w, result_src_e, pc_src_e, mc_start_e, mc_done,
    output forward_a_e, forward_b_e,
    output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller for a 5-stage RV32I core.
// Forwarding selects, load-use stalls stretched to LOAD_LAT bubbles, branch
// flushes and a MUL/DIV stall handshake. State and counter are registered,
// all stall/flush/forward outputs are combinational.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall_cyc and
// flush_cyc performance counters as extra output ports.
module hazard_ctrl_mc #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_mc_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cyc,
  output logic [CNT_W-1:0] flush_cyc
`endif
);

  localparam int LC_W = $clog2(LOAD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    MC_BUSY = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LC_W-1:0]   cnt_q, cnt_d;
  logic              ld_hit;
  logic              br_flush;

  // Pick the forwarding source for one Execute operand; M beats W, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              we_w);
    if (we_m && (rd_m != '0) && (rd_m == rs))      return 2'b10;
    else if (we_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
    else                                           return 2'b00;
  endfunction

  // Forwarding selects, forced to register-file source while in reset.
  always_comb begin
    hz.forward_a_e = 2'b00;
    hz.forward_b_e = 2'b00;
    if (!rst) begin
      hz.forward_a_e = fwd_sel(hz.rs1_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);
      hz.forward_b_e = fwd_sel(hz.rs2_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);
    end
  end

  assign ld_hit = (hz.result_src_e == 2'b01) && (hz.rd_e != '0) &&
                  ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

  // Next-state and stall/flush decode; outputs stay low throughout reset.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    hz.stall_f = 1'b0;
    hz.stall_d = 1'b0;
    hz.stall_e = 1'b0;
    hz.flush_d = 1'b0;
    hz.flush_e = 1'b0;
    hz.flush_m = 1'b0;
    br_flush   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (hz.pc_src_e) begin
            // Taken branch squashes whatever hazard the wrong-path instructions raised.
            hz.flush_d = 1'b1;
            hz.flush_e = 1'b1;
            br_flush   = 1'b1;
          end else if (hz.mc_start_e) begin
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            hz.stall_e = 1'b1;
            hz.flush_m = 1'b1;
            state_d    = MC_BUSY;
          end else if (ld_hit) begin
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            hz.flush_e = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LD_WAIT;
              cnt_d   = LC_W'(LOAD_LAT - 1);
            end
          end
        end
        LD_WAIT: begin
          // E already holds a bubble, so a pc_src_e here cannot be real.
          hz.stall_f = 1'b1;
          hz.stall_d = 1'b1;
          hz.flush_e = 1'b1;
          cnt_d      = cnt_q - LC_W'(1);
          if (cnt_q == LC_W'(1)) state_d = IDLE;
        end
        MC_BUSY: begin
          if (hz.mc_done) begin
            state_d = IDLE;
          end else begin
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            hz.stall_e = 1'b1;
            hz.flush_m = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and load-wait counter registers; reset aborts any stall in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0] flush_cyc_q, flush_cyc_d;

  // Saturating increments for the performance counters.
  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cyc_d = flush_cyc_q;
    if (hz.stall_d && (stall_cyc_q != '1)) stall_cyc_d = stall_cyc_q + CNT_W'(1);
    if (br_flush   && (flush_cyc_q != '1)) flush_cyc_d = flush_cyc_q + CNT_W'(1);
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cyc_q <= '0;
      flush_cyc_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cyc_q <= flush_cyc_d;
    end
  end

  assign stall_cyc = stall_cyc_q;
  assign flush_cyc = flush_cyc_q;
`endif

endmodule
